// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multicycle core.
// It accepts one fetch/load/store request at a time and waits WAIT cycles.
// It then performs a word access on an internal array and returns exactly
// one single-cycle response.
// Handshake: a request is taken on a rising edge where req_valid && req_ready.
// req_valid while req_ready=0 is ignored, so the initiator must hold or
// re-present the request. rsp_valid is a one-cycle pulse, and rsp_rdata and
// rsp_err are meaningful only while rsp_valid=1.
// Optional build macro: MEM_CLEAR_ON_RESET_EN. When it is defined, the array
// is zeroed one word per cycle after reset, before the first request is
// accepted.
module mem_responder #(
    parameter int DEPTH_LOG2 = 6,
    parameter int WAIT       = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    // r_state is the FSM state observed by checkers.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
`ifdef MEM_CLEAR_ON_RESET_EN
        S_RESP  = 2'd2,
        S_CLEAR = 2'd3
`else
        S_RESP  = 2'd2
`endif
    } state_t;

    logic [31:0]           r_mem [DEPTH];
    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_we;
    logic [DEPTH_LOG2-1:0] r_index;
    logic [31:0]           r_wdata;
    logic                  r_fault;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic                  r_busy;
    logic                  r_req_ready;
`ifdef MEM_CLEAR_ON_RESET_EN
    logic [DEPTH_LOG2-1:0] r_clr_idx;
`endif

    // Decode of the incoming address. A fault is a misaligned address or any
    // set bit above the index field. This keeps out-of-range addresses from
    // aliasing onto real words.
    logic                  w_fault_in;
    logic [DEPTH_LOG2-1:0] w_index_in;
    logic                  w_commit;
    assign w_fault_in = (req_addr[1:0] != 2'b00) || (req_addr[31:DEPTH_LOG2+2] != '0);
    assign w_index_in = req_addr[DEPTH_LOG2+1:2];
    // A store commits on the RESP edge only. A reset on that edge drops it.
    assign w_commit   = (r_state == S_RESP) && r_we && !r_fault && !reset;

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign busy      = r_busy;
    // Combinational read in RESP. The output is zero for stores, faults and
    // all other states.
    assign rsp_rdata = ((r_state == S_RESP) && !r_we && !r_fault) ? r_mem[r_index] : 32'd0;

    // Word array. It has no reset, so the contents survive reset unless the
    // clear sequence runs.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[r_index] <= r_wdata;
        end
`ifdef MEM_CLEAR_ON_RESET_EN
        if (!reset && (r_state == S_CLEAR)) begin
            r_mem[r_clr_idx] <= 32'd0;
        end
`endif
    end

    // Control FSM with registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_index     <= '0;
            r_wdata     <= 32'd0;
            r_fault     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
`ifdef MEM_CLEAR_ON_RESET_EN
            r_state     <= S_CLEAR;
            r_clr_idx   <= '0;
            r_busy      <= 1'b1;
            r_req_ready <= 1'b0;
`else
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_req_ready <= 1'b1;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_index     <= w_index_in;
                        r_wdata     <= req_wdata;
                        r_fault     <= w_fault_in;
                        r_busy      <= 1'b1;
                        r_req_ready <= 1'b0;
                        if (WAIT > 0) begin
                            r_state <= S_WAIT;
                            r_cnt   <= WAIT_CNT;
                        end else begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= w_fault_in;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= r_fault;
                    end
                end
                S_RESP: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_req_ready <= 1'b1;
                end
`ifdef MEM_CLEAR_ON_RESET_EN
                S_CLEAR: begin
                    r_clr_idx <= r_clr_idx + 1'b1;
                    if (r_clr_idx == '1) begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
`endif
                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder. The main instance uses WAIT=2. A second
// instance uses WAIT=0 for the back-to-back throughput pattern. Build with
// MEM_CLEAR_ON_RESET_EN to exercise the clear sequence with DEPTH_LOG2=4.
module tb_mem_responder;

`ifdef MEM_CLEAR_ON_RESET_EN
    localparam int          DL        = 4;
    localparam logic        RST_BUSY  = 1'b1;
    localparam logic        RST_READY = 1'b0;
    localparam logic [31:0] EXP_20    = 32'h0000_0000;
`else
    localparam int          DL        = 6;
    localparam logic        RST_BUSY  = 1'b0;
    localparam logic        RST_READY = 1'b1;
    localparam logic [31:0] EXP_20    = 32'hA5A5_A5A5;
`endif
    localparam int WAIT_P = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;

    logic        req_valid0, req_we0;
    logic [31:0] req_addr0, req_wdata0;
    logic        req_ready0, rsp_valid0, rsp_err0, busy0;
    logic [31:0] rsp_rdata0;

    int n_checks = 0;
    int n_fail   = 0;

    mem_responder #(.DEPTH_LOG2(DL), .WAIT(WAIT_P)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    mem_responder #(.DEPTH_LOG2(DL), .WAIT(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid0), .req_we(req_we0), .req_addr(req_addr0), .req_wdata(req_wdata0),
        .req_ready(req_ready0), .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0),
        .rsp_err(rsp_err0), .busy(busy0)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Called #1 after a rising edge with the main instance idle.
    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
        logic        got;
        int          lat;
        logic [31:0] rd;
        logic        er;
        check_eq({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        got = 1'b0; lat = -1; rd = 32'd0; er = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1; lat = k; rd = rsp_rdata; er = rsp_err;
            end
        end
        check_eq({tag, "_rsp_seen"}, 32'(got), 32'd1);
        check_eq({tag, "_latency"}, 32'(lat), 32'(WAIT_P));
        check_eq({tag, "_rdata"}, rd, exp_rdata);
        check_eq({tag, "_err"}, 32'(er), 32'(exp_err));
        @(posedge clk); #1;
        check_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
        check_eq({tag, "_rsp_pulse"}, 32'(rsp_valid), 32'd0);
    endtask

    // Bounded wait until the main instance is idle, then realigns to #1 after an edge.
    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_idle_timeout"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          nb, viol, nrsp;
        logic [7:0]  rv, sv;
        logic [31:0] rd_or;

        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = 32'd0; req_wdata0 = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rdata", rsp_rdata, 32'd0);
        check_eq("rst_err", 32'(rsp_err), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'(RST_BUSY));
        check_eq("rst_ready", 32'(req_ready), 32'(RST_READY));
        reset = 1'b0;

`ifdef MEM_CLEAR_ON_RESET_EN
        nb = 0; viol = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy) begin
                nb++;
                if (req_ready) viol++;
            end
        end
        @(posedge clk); #1;
        check_eq("clear_busy_cycles", 32'(nb), 32'd16);
        check_eq("clear_ready_low", 32'(viol), 32'd0);
        txn("clear_load_3c", 1'b0, 32'h0000_003C, 32'd0, 32'd0, 1'b0);
`endif

        // Store, then an immediate load of the same word.
        txn("st_10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, 1'b0);
        txn("ld_10", 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0);
        // Misaligned load faults, and the data is unchanged.
        txn("ld_12_mis", 1'b0, 32'h0000_0012, 32'd0, 32'd0, 1'b1);
        txn("ld_10_again", 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0);
        // Out-of-range store must not alias onto word 0.
        txn("st_00", 1'b1, 32'h0000_0000, 32'h1111_1111, 32'd0, 1'b0);
        txn("st_100_oor", 1'b1, 32'h0000_0100, 32'hBAD0_BAD0, 32'd0, 1'b1);
        txn("ld_00", 1'b0, 32'h0000_0000, 32'd0, 32'h1111_1111, 1'b0);
        // Read-after-write on another word.
        txn("st_04", 1'b1, 32'h0000_0004, 32'hCAFE_F00D, 32'd0, 1'b0);
        txn("ld_04", 1'b0, 32'h0000_0004, 32'd0, 32'hCAFE_F00D, 1'b0);
        txn("ld_08_oor_hi", 1'b0, 32'h8000_0008, 32'd0, 32'd0, 1'b1);

        // Reset during the WAIT of a store: no response, no write.
        txn("st_20_pre", 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 32'd0, 1'b0);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0020; req_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        nrsp = 0;
        @(negedge clk); if (rsp_valid) nrsp++;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk); if (rsp_valid) nrsp++;
        @(posedge clk); #1;
        check_eq("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("midrst_rdata", rsp_rdata, 32'd0);
        check_eq("midrst_err", 32'(rsp_err), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'(RST_BUSY));
        check_eq("midrst_ready", 32'(req_ready), 32'(RST_READY));
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); if (rsp_valid) nrsp++;
        end
        check_eq("midrst_no_rsp", 32'(nrsp), 32'd0);
        @(posedge clk); #1;
        wait_idle("midrst");
        txn("ld_20_after_rst", 1'b0, 32'h0000_0020, 32'd0, EXP_20, 1'b0);

        // WAIT=0 instance: continuous req_valid gives ready 1,0,1,0 and one response per two cycles.
        nb = 0;
        while (busy0 && nb < 100) begin
            @(negedge clk); nb++;
        end
        @(posedge clk); #1;
        req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = 32'h0000_0008; req_wdata0 = 32'h55AA_55AA;
        rv = 8'd0; sv = 8'd0; rd_or = 32'd0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            rv[k] = req_ready0;
            sv[k] = rsp_valid0;
            if (rsp_valid0) rd_or = rd_or | rsp_rdata0 | 32'(rsp_err0);
        end
        @(posedge clk); #1;
        req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = 32'd0; req_wdata0 = 32'd0;
        check_eq("w0_ready_pattern", 32'(rv), 32'h55);
        check_eq("w0_rsp_pattern", 32'(sv), 32'hAA);
        check_eq("w0_store_rsp_zero", rd_or, 32'd0);
        req_valid0 = 1'b1; req_addr0 = 32'h0000_0008;
        @(negedge clk);
        check_eq("w0_load_ready", 32'(req_ready0), 32'd1);
        @(posedge clk); #1;
        req_valid0 = 1'b0; req_addr0 = 32'd0;
        @(negedge clk);
        check_eq("w0_load_valid", 32'(rsp_valid0), 32'd1);
        check_eq("w0_load_rdata", rsp_rdata0, 32'h55AA_55AA);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle core's memory interface.
- The core's control FSM is the initiator: it issues fetch, load and store requests. This block accepts each request, inserts a fixed number of wait states, performs the word read or write on an internal array, and returns exactly one response.
- Sits between the core's address mux (adr_src) / mem_w path and the shared instruction/data store.

Parameters:
- DEPTH_LOG2, 6, log2 of the word count of the internal array (64 words at default).
- WAIT, 2, wait-state cycles between request acceptance and response; legal range 0..15.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  initiator presents a request.
- req_we  in  1  1 = store, 0 = load/fetch.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_ready  out  1  responder can accept a request this cycle.
- rsp_valid  out  1  response valid; one-cycle pulse.
- rsp_rdata  out  32  load data; 0 on a store or an error.
- rsp_err  out  1  address fault, qualified by rsp_valid.
- busy  out  1  a transaction is in flight, or the clear sequence is running.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, req_ready=1. Array contents are untouched unless the optional feature is enabled.
- States: IDLE, WAIT, RESP (plus CLEAR with the optional feature).
- IDLE:
  - req_ready=1.
  - When req_valid=1: register we/addr/wdata, set busy=1.
  - Next state is WAIT with counter=WAIT if WAIT>0, else RESP.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - Move to RESP in the cycle the counter reaches 0.
- RESP (exactly one cycle):
  - rsp_valid=1; write commits on this edge when we=1 and no error.
  - rsp_rdata = array[index] for a valid load; 0 otherwise.
  - Next state IDLE; busy=0 in the following cycle.
- Latency: request accepted on edge t gives rsp_valid high in cycle t+WAIT+1. Back-to-back throughput is one transaction per WAIT+2 cycles.
- Address decode:
  - index = req_addr[DEPTH_LOG2+1:2].
  - Fault if req_addr[1:0]!=0 (misaligned) or any req_addr bit above DEPTH_LOG2+1 is 1 (out of range).
  - On a fault: rsp_err=1, rsp_rdata=0, no write.
- req_valid while req_ready=0 is ignored; no queuing. The initiator must hold or re-present the request.
- Read-after-write: a load accepted the cycle after a store's response returns the new data.
- Reset mid-transaction: the transaction is dropped, no write commits, no response is issued.
- Array is word-wide only (no byte lanes) and is read combinationally in RESP.

Optional Feature:
- MEM_CLEAR_ON_RESET_EN.
- Defined:
  - After reset deasserts, enter CLEAR instead of IDLE.
  - Write 0 to index 0..2^DEPTH_LOG2-1, one word per cycle.
  - busy=1 and req_ready=0 throughout; enter IDLE after the last index, 2^DEPTH_LOG2 cycles.
  - Reset asserted during CLEAR restarts the sequence from index 0.
- Undefined: no CLEAR state; IDLE immediately after reset; array contents undefined until written.

Test Plan:
- WAIT=2: store addr 0x00000010 data 0xDEADBEEF accepted at cycle 5, then load of 0x10 → store rsp_valid at cycle 8 with rsp_err=0 and rsp_rdata=0; load returns 0xDEADBEEF at acceptance+3.
- Load addr 0x00000012 (misaligned) → rsp_err=1, rsp_rdata=0; a later load of 0x10 still returns the earlier data.
- Store to 0x00000100 with DEPTH_LOG2=6 (out of range) → rsp_err=1; loads of 0x00 still return the prior contents, confirming no aliasing write.
- req_valid held high continuously with WAIT=0 → req_ready pattern 1,0 repeating; exactly one rsp_valid per two cycles; no duplicate accepts.
- Reset asserted during WAIT of a store to 0x20 with data 0x12345678 → no rsp_valid; a subsequent load of 0x20 does not return 0x12345678; all outputs are at reset values one cycle after reset.
- MEM_CLEAR_ON_RESET_EN, DEPTH_LOG2=4: after reset, busy=1 for exactly 16 cycles with req_ready=0; then a load of 0x3C returns 0.
